// File: rtl/cmd_pkg.sv
// Shared definitions for the command register bank: FSM encoding, tdest codes,
// host command words and the address field width.
package cmd_pkg;

   localparam int ADDR_W = 8;

   localparam logic [3:0] DEST_NONE   = 4'd0;
   localparam logic [3:0] DEST_WRITE  = 4'd1;
   localparam logic [3:0] DEST_STATUS = 4'd2;
   localparam logic [3:0] DEST_READ   = 4'd3;

   // ASCII command words as emitted by the host in the packet header
   localparam logic [31:0] CMD_WWCC = 32'h5757_4343;
   localparam logic [31:0] CMD_WWFF = 32'h5757_4646;
   localparam logic [31:0] CMD_WWDA = 32'h5757_4441;
   localparam logic [31:0] CMD_RRCC = 32'h5252_4343;
   localparam logic [31:0] CMD_RRFF = 32'h5252_4646;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_WR_ADDR = 3'd1;
   localparam logic [2:0] ST_WR_DATA = 3'd2;
   localparam logic [2:0] ST_RD_ADDR = 3'd3;
   localparam logic [2:0] ST_DROP    = 3'd4;

   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      WR_ADDR = ST_WR_ADDR,
      WR_DATA = ST_WR_DATA,
      RD_ADDR = ST_RD_ADDR,
      DROP    = ST_DROP
   } state_t;

endpackage

// File: rtl/cmd_reg_bank_rsp_reg.sv
// Single-entry AXI-Stream output register. Handshake: a beat moves on valid & ready;
// o_valid holds with stable o_data until i_ready, and a new beat may load in the same cycle.
module cmd_reg_bank_rsp_reg #(
   parameter int W = 65
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [W-1:0] i_data,
   input  logic         i_valid,
   output logic         o_ready,
   output logic [W-1:0] o_data,
   output logic         o_valid,
   input  logic         i_ready
);

   logic         r_valid;
   logic [W-1:0] r_data;

   assign o_ready = !r_valid || i_ready;
   assign o_valid = r_valid;
   assign o_data  = r_data;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_valid && o_ready) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end else if (i_ready) begin
         r_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/cmd_reg_bank.sv
// Executes decoded host command packets against a bank of 32-bit control registers.
// Read-back path is built only when CMD_REG_BANK_READBACK_EN is defined.
module cmd_reg_bank
   import cmd_pkg::*;
#(
   parameter int          NUM_REG       = 7,
   parameter logic [3:0]  WRITE_DEST    = DEST_WRITE,
   parameter logic [3:0]  READ_DEST     = DEST_READ,
   parameter logic [31:0] BAD_ADDR_WORD = 32'hDEADBEEF
) (
   input  logic                  axi_tclk,
   input  logic                  axi_treset,
   input  logic [31:0]           s_axis_tdata,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tlast,
   input  logic [3:0]            s_axis_tdest,
   input  logic [31:0]           s_axis_tuser,
   output logic                  s_axis_tready,
   output logic [31:0]           m_axis_tdata,
   output logic                  m_axis_tvalid,
   output logic                  m_axis_tlast,
   output logic [31:0]           m_axis_tuser,
   input  logic                  m_axis_tready,
   output logic [32*NUM_REG-1:0] reg_bank,
   output logic [NUM_REG-1:0]    reg_wr_strobe,
   output logic [15:0]           err_count,
   output logic                  busy,
   output state_t                o_dbg_state
);

   localparam logic [ADDR_W:0] LP_NUM = (ADDR_W+1)'(NUM_REG);

   state_t              r_state, w_next;
   logic [31:0]         r_regs [NUM_REG];
   logic [NUM_REG-1:0]  r_strobe;
   logic [ADDR_W-1:0]   r_addr;
   logic [15:0]         r_err;
   logic w_ready, w_hs, w_wr_en, w_err_inc, w_rd_push, w_rsp_ready, w_rd_oor, w_unused;

   always_comb begin
      w_ready = 1'b1;
      if (r_state == RD_ADDR) w_ready = w_rsp_ready;
   end

   assign s_axis_tready = w_ready && !axi_treset;
   assign w_hs          = s_axis_tvalid && s_axis_tready;

   always_comb begin
      w_next    = r_state;
      w_wr_en   = 1'b0;
      w_err_inc = 1'b0;
      w_rd_push = 1'b0;
      case (r_state)
         IDLE: begin
            // a header with tlast is an empty packet and is silently consumed
            if (w_hs && !s_axis_tlast) begin
               if (s_axis_tdest == WRITE_DEST) w_next = WR_ADDR;
`ifdef CMD_REG_BANK_READBACK_EN
               else if (s_axis_tdest == READ_DEST) w_next = RD_ADDR;
`else
               else if (s_axis_tdest == READ_DEST) w_next = DROP;
`endif
               else w_next = DROP;
            end
         end
         WR_ADDR: begin
            if (w_hs) begin
               if (s_axis_tlast) begin
                  w_err_inc = 1'b1;
                  w_next    = IDLE;
               end else begin
                  w_next = WR_DATA;
               end
            end
         end
         WR_DATA: begin
            if (w_hs) begin
               if ({1'b0, r_addr} < LP_NUM) w_wr_en = 1'b1;
               else w_err_inc = 1'b1;
               w_next = s_axis_tlast ? IDLE : WR_ADDR;
            end
         end
         RD_ADDR: begin
            if (w_hs) begin
               w_rd_push = 1'b1;
               w_err_inc = w_rd_oor;
               if (s_axis_tlast) w_next = IDLE;
            end
         end
         DROP: begin
            if (w_hs && s_axis_tlast) begin
               w_err_inc = 1'b1;
               w_next    = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge axi_tclk) begin
      if (axi_treset) begin
         r_state  <= IDLE;
         r_addr   <= '0;
         r_strobe <= '0;
         r_err    <= '0;
         for (int i = 0; i < NUM_REG; i++) r_regs[i] <= '0;
      end else begin
         r_state  <= w_next;
         r_strobe <= '0;
         if (r_state == WR_ADDR && w_hs) r_addr <= s_axis_tdata[ADDR_W-1:0];
         if (w_err_inc && r_err != 16'hFFFF) r_err <= r_err + 16'd1;
         for (int i = 0; i < NUM_REG; i++) begin
            if (w_wr_en && r_addr == ADDR_W'(i)) begin
               r_regs[i]   <= s_axis_tdata;
               r_strobe[i] <= 1'b1;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_REG; g++) begin : g_flat
      assign reg_bank[32*g +: 32] = r_regs[g];
   end

   assign reg_wr_strobe = r_strobe;
   assign err_count     = r_err;
   assign busy          = (r_state != IDLE);
   assign o_dbg_state   = r_state;

`ifdef CMD_REG_BANK_READBACK_EN
   logic [ADDR_W-1:0] w_rd_addr;
   logic [31:0]       w_rd_word;
   logic [64:0]       w_rsp_data;

   assign w_rd_addr = s_axis_tdata[ADDR_W-1:0];
   assign w_rd_oor  = ({1'b0, w_rd_addr} >= LP_NUM);

   always_comb begin
      w_rd_word = BAD_ADDR_WORD;
      for (int i = 0; i < NUM_REG; i++) begin
         if (w_rd_addr == ADDR_W'(i)) w_rd_word = r_regs[i];
      end
   end

   cmd_reg_bank_rsp_reg #(.W(65)) u_rsp (
      .i_clk   (axi_tclk),
      .i_rst   (axi_treset),
      .i_data  ({s_axis_tlast, s_axis_tuser, w_rd_word}),
      .i_valid (w_rd_push),
      .o_ready (w_rsp_ready),
      .o_data  (w_rsp_data),
      .o_valid (m_axis_tvalid),
      .i_ready (m_axis_tready)
   );

   assign {m_axis_tlast, m_axis_tuser, m_axis_tdata} = w_rsp_data;
   assign w_unused = ^s_axis_tdata[31:ADDR_W];
`else
   assign w_rsp_ready   = 1'b0;
   assign w_rd_oor      = 1'b0;
   assign m_axis_tdata  = '0;
   assign m_axis_tvalid = 1'b0;
   assign m_axis_tlast  = 1'b0;
   assign m_axis_tuser  = '0;
   assign w_unused      = ^{s_axis_tdata[31:ADDR_W], s_axis_tuser, m_axis_tready, w_rd_push};
`endif

endmodule

// File: tb/tb_cmd_reg_bank.sv
// Directed bench for cmd_reg_bank; read-path expectations follow CMD_REG_BANK_READBACK_EN.
module tb_cmd_reg_bank;
   import cmd_pkg::*;

   localparam int NR = 7;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [31:0]       s_axis_tdata = '0;
   logic              s_axis_tvalid = 1'b0;
   logic              s_axis_tlast = 1'b0;
   logic [3:0]        s_axis_tdest = '0;
   logic [31:0]       s_axis_tuser = '0;
   logic              s_axis_tready;
   logic [31:0]       m_axis_tdata;
   logic              m_axis_tvalid;
   logic              m_axis_tlast;
   logic [31:0]       m_axis_tuser;
   logic              m_axis_tready = 1'b1;
   logic [32*NR-1:0]  reg_bank;
   logic [NR-1:0]     reg_wr_strobe;
   logic [15:0]       err_count;
   logic              busy;
   state_t            dbg_state;

   int errors = 0;
   int checks = 0;
   int stalls = 0;
   int rsp_seen = 0;
   logic [64:0]       exp_q[$];
   logic [NR-1:0]     strb_q[$];
   logic [64:0]       mon_exp;
   logic [32*NR-1:0]  exp_bank = '0;

   always #5 clk = ~clk;

   cmd_reg_bank #(.NUM_REG(NR)) dut (
      .axi_tclk      (clk),
      .axi_treset    (rst),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tdest  (s_axis_tdest),
      .s_axis_tuser  (s_axis_tuser),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tready (m_axis_tready),
      .reg_bank      (reg_bank),
      .reg_wr_strobe (reg_wr_strobe),
      .err_count     (err_count),
      .busy          (busy),
      .o_dbg_state   (dbg_state)
   );

   // scoreboard: strobe log and response checking against exp_q
   always @(negedge clk) begin
      if (reg_wr_strobe != '0) strb_q.push_back(reg_wr_strobe);
      if (m_axis_tvalid && m_axis_tready) begin
         checks++;
         rsp_seen++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: got %h, expected no response", {m_axis_tlast, m_axis_tuser, m_axis_tdata});
         end else begin
            mon_exp = exp_q.pop_front();
            if ({m_axis_tlast, m_axis_tuser, m_axis_tdata} !== mon_exp) begin
               errors++;
               $display("FAIL rsp_data: got %h, expected %h", {m_axis_tlast, m_axis_tuser, m_axis_tdata}, mon_exp);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic send_beat(input logic [31:0] d, input logic [3:0] dest, input logic [31:0] user, input logic last);
      int n;
      @(negedge clk);
      s_axis_tdata  = d;
      s_axis_tdest  = dest;
      s_axis_tuser  = user;
      s_axis_tlast  = last;
      s_axis_tvalid = 1'b1;
      n = 0;
      while (!s_axis_tready && n < 50) begin
         stalls++;
         @(negedge clk);
         n++;
      end
      checks++;
      if (!s_axis_tready) begin
         errors++;
         $display("FAIL tready_timeout: got tready=%b, expected 1 within 50 cycles", s_axis_tready);
      end
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL rsp_drain: got %0d pending, expected 0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL reset_tready_in_reset: got %b, expected 0", s_axis_tready); end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (reg_bank !== '0) begin errors++; $display("FAIL reset_bank: got %h, expected 0", reg_bank); end
      checks++;
      if ({reg_wr_strobe, err_count, busy} !== '0) begin errors++; $display("FAIL reset_status: got strb=%b err=%0d busy=%b, expected all 0", reg_wr_strobe, err_count, busy); end
      checks++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata} !== '0) begin errors++; $display("FAIL reset_m_axis: got v=%b l=%b u=%h d=%h, expected 0", m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata); end
      checks++;
      if (s_axis_tready !== 1'b1 || dbg_state !== IDLE) begin errors++; $display("FAIL reset_idle: got tready=%b state=%0d, expected 1/IDLE", s_axis_tready, dbg_state); end
   endtask

   task automatic test_write();
      strb_q.delete();
      send_beat(CMD_WWCC, DEST_WRITE, 32'h1, 1'b0);
      send_beat(32'h0, DEST_WRITE, 32'h1, 1'b0);
      send_beat(32'h1111_1111, DEST_WRITE, 32'h1, 1'b0);
      send_beat(32'hFFFF_FF03, DEST_WRITE, 32'h1, 1'b0);
      send_beat(32'h3333_3333, DEST_WRITE, 32'h1, 1'b1);
      idle();
      repeat (2) @(negedge clk);
      exp_bank[31:0]   = 32'h1111_1111;
      exp_bank[127:96] = 32'h3333_3333;
      checks++;
      if (reg_bank !== exp_bank) begin errors++; $display("FAIL write_bank: got %h, expected %h", reg_bank, exp_bank); end
      checks++;
      if (strb_q.size() != 2) begin
         errors++; $display("FAIL write_strobe_count: got %0d, expected 2", strb_q.size());
      end else if (strb_q[0] !== 7'b0000001 || strb_q[1] !== 7'b0001000) begin
         errors++; $display("FAIL write_strobe: got %b,%b, expected 0000001,0001000", strb_q[0], strb_q[1]);
      end
      checks++;
      if (err_count !== 16'd0 || busy !== 1'b0) begin errors++; $display("FAIL write_err: got err=%0d busy=%b, expected 0/0", err_count, busy); end
   endtask

   task automatic test_oor_write();
      strb_q.delete();
      send_beat(CMD_WWDA, DEST_WRITE, 32'h2, 1'b0);
      send_beat(32'h9, DEST_WRITE, 32'h2, 1'b0);
      send_beat(32'hAAAA_5555, DEST_WRITE, 32'h2, 1'b1);
      idle();
      repeat (2) @(negedge clk);
      checks++;
      if (reg_bank !== exp_bank) begin errors++; $display("FAIL oor_bank: got %h, expected %h", reg_bank, exp_bank); end
      checks++;
      if (strb_q.size() != 0) begin errors++; $display("FAIL oor_strobe: got %0d pulses, expected 0", strb_q.size()); end
      checks++;
      if (err_count !== 16'd1) begin errors++; $display("FAIL oor_err: got %0d, expected 1", err_count); end
   endtask

   task automatic test_odd_write();
      strb_q.delete();
      send_beat(CMD_WWCC, DEST_WRITE, 32'h3, 1'b0);
      send_beat(32'h2, DEST_WRITE, 32'h3, 1'b1);
      idle();
      @(negedge clk);
      checks++;
      if (err_count !== 16'd2 || busy !== 1'b0 || reg_bank !== exp_bank || strb_q.size() != 0) begin
         errors++; $display("FAIL odd_write: got err=%0d busy=%b strobes=%0d, expected 2/0/0", err_count, busy, strb_q.size());
      end
      send_beat(CMD_WWCC, DEST_WRITE, 32'h4, 1'b0);
      send_beat(32'h2, DEST_WRITE, 32'h4, 1'b0);
      send_beat(32'h2222_2222, DEST_WRITE, 32'h4, 1'b1);
      idle();
      repeat (2) @(negedge clk);
      exp_bank[95:64] = 32'h2222_2222;
      checks++;
      if (reg_bank !== exp_bank) begin errors++; $display("FAIL odd_recover_bank: got %h, expected %h", reg_bank, exp_bank); end
      checks++;
      if (strb_q.size() != 1) begin
         errors++; $display("FAIL odd_recover_strobe_count: got %0d, expected 1", strb_q.size());
      end else if (strb_q[0] !== 7'b0000100) begin
         errors++; $display("FAIL odd_recover_strobe: got %b, expected 0000100", strb_q[0]);
      end
   endtask

   task automatic test_read();
      int seen0;
      seen0 = rsp_seen;
`ifdef CMD_REG_BANK_READBACK_EN
      exp_q.push_back({1'b0, 32'h42, 32'h1111_1111});
      exp_q.push_back({1'b0, 32'h42, 32'h3333_3333});
      exp_q.push_back({1'b1, 32'h42, 32'hDEAD_BEEF});
      fork
         begin
            send_beat(CMD_RRCC, DEST_READ, 32'h42, 1'b0);
            send_beat(32'h0, DEST_READ, 32'h42, 1'b0);
            send_beat(32'h3, DEST_READ, 32'h42, 1'b0);
            send_beat(32'h8, DEST_READ, 32'h42, 1'b1);
            idle();
         end
         begin
            @(posedge clk); #1 m_axis_tready = 1'b1;
            @(posedge clk); #1 m_axis_tready = 1'b0;
            @(posedge clk); #1 m_axis_tready = 1'b0;
            @(posedge clk); #1 m_axis_tready = 1'b1;
         end
      join
      drain();
      checks++;
      if (rsp_seen - seen0 != 3) begin errors++; $display("FAIL read_count: got %0d, expected 3", rsp_seen - seen0); end
`else
      send_beat(CMD_RRCC, DEST_READ, 32'h42, 1'b0);
      send_beat(32'h0, DEST_READ, 32'h42, 1'b0);
      send_beat(32'h3, DEST_READ, 32'h42, 1'b0);
      send_beat(32'h8, DEST_READ, 32'h42, 1'b1);
      idle();
      repeat (3) @(negedge clk);
      checks++;
      if (rsp_seen != seen0 || m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL read_disabled_rsp: got %0d responses valid=%b, expected 0/0", rsp_seen - seen0, m_axis_tvalid); end
`endif
      checks++;
      if (err_count !== 16'd3 || busy !== 1'b0) begin errors++; $display("FAIL read_err: got err=%0d busy=%b, expected 3/0", err_count, busy); end
   endtask

   task automatic test_back_to_back();
      int st0;
      logic [15:0] exp_err;
      m_axis_tready = 1'b1;
      st0 = stalls;
`ifdef CMD_REG_BANK_READBACK_EN
      exp_err = 16'd3;
      exp_q.push_back({1'b0, 32'h7, 32'h1111_1111});
      exp_q.push_back({1'b0, 32'h7, 32'h2222_2222});
      exp_q.push_back({1'b0, 32'h7, 32'h3333_3333});
      exp_q.push_back({1'b1, 32'h7, 32'h0000_0000});
`else
      exp_err = 16'd4;
`endif
      send_beat(CMD_RRFF, DEST_READ, 32'h7, 1'b0);
      send_beat(32'h0, DEST_READ, 32'h7, 1'b0);
      send_beat(32'h2, DEST_READ, 32'h7, 1'b0);
      send_beat(32'h3, DEST_READ, 32'h7, 1'b0);
      send_beat(32'h1, DEST_READ, 32'h7, 1'b1);
      idle();
      drain();
      checks++;
      if (stalls != st0) begin errors++; $display("FAIL b2b_stalls: got %0d, expected 0", stalls - st0); end
      checks++;
      if (err_count !== exp_err) begin errors++; $display("FAIL b2b_err: got %0d, expected %0d", err_count, exp_err); end
   endtask

   task automatic test_drop();
      int st0;
      int seen0;
      logic [15:0] exp_err;
      st0 = stalls;
      seen0 = rsp_seen;
      strb_q.delete();
`ifdef CMD_REG_BANK_READBACK_EN
      exp_err = 16'd4;
`else
      exp_err = 16'd5;
`endif
      send_beat(CMD_WWCC, 4'd5, 32'h9, 1'b0);
      send_beat(32'h0, 4'd5, 32'h9, 1'b0);
      send_beat(32'h1234_5678, 4'd5, 32'h9, 1'b0);
      send_beat(32'h1, 4'd5, 32'h9, 1'b1);
      idle();
      repeat (2) @(negedge clk);
      checks++;
      if (stalls != st0) begin errors++; $display("FAIL drop_stalls: got %0d, expected 0", stalls - st0); end
      checks++;
      if (err_count !== exp_err || busy !== 1'b0) begin errors++; $display("FAIL drop_err: got err=%0d busy=%b, expected %0d/0", err_count, busy, exp_err); end
      checks++;
      if (strb_q.size() != 0 || rsp_seen != seen0 || reg_bank !== exp_bank) begin
         errors++; $display("FAIL drop_side_effect: got strobes=%0d rsp=%0d, expected 0/0", strb_q.size(), rsp_seen - seen0);
      end
   endtask

   task automatic test_reset_mid();
`ifdef CMD_REG_BANK_READBACK_EN
      m_axis_tready = 1'b0;
      send_beat(CMD_RRCC, DEST_READ, 32'h5, 1'b0);
      send_beat(32'h0, DEST_READ, 32'h5, 1'b0);
      idle();
      checks++;
      if (m_axis_tvalid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL mid_pre: got valid=%b busy=%b, expected 1/1", m_axis_tvalid, busy); end
`else
      send_beat(CMD_WWCC, 4'd5, 32'h5, 1'b0);
      send_beat(32'h0, 4'd5, 32'h5, 1'b0);
      idle();
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL mid_pre: got busy=%b, expected 1", busy); end
`endif
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || dbg_state !== IDLE) begin errors++; $display("FAIL mid_reset: got valid=%b busy=%b, expected 0/0", m_axis_tvalid, busy); end
      checks++;
      if (reg_bank !== '0 || err_count !== 16'd0) begin errors++; $display("FAIL mid_reset_regs: got bank=%h err=%0d, expected 0/0", reg_bank, err_count); end
      rst = 1'b0;
      m_axis_tready = 1'b1;
      exp_bank = '0;
      exp_bank[63:32] = 32'h5A5A_5A5A;
      send_beat(CMD_WWCC, DEST_WRITE, 32'h6, 1'b0);
      send_beat(32'h1, DEST_WRITE, 32'h6, 1'b0);
      send_beat(32'h5A5A_5A5A, DEST_WRITE, 32'h6, 1'b1);
      idle();
      repeat (2) @(negedge clk);
      checks++;
      if (reg_bank !== exp_bank || err_count !== 16'd0) begin errors++; $display("FAIL mid_recover: got bank=%h err=%0d, expected %h/0", reg_bank, err_count, exp_bank); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_oor_write();
      test_odd_write();
      test_read();
      test_back_to_back();
      test_drop();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
